// File: rtl/axi_node_pkg.sv
// rtl/axi_node_pkg.sv - shared types and constants for the AXI node response path
package axi_node_pkg;

  localparam int BEAT_CNT_W = 16;
  localparam int DEF_ID_W   = 16;
  localparam int DEF_AUX_W  = 32;

  // Modules re-declare this layout with their own parameter widths.
  typedef struct packed {
    logic [DEF_ID_W-1:0]  id;
    logic [DEF_AUX_W-1:0] aux;
    logic                 last;
  } resp_entry_t;

  function automatic int entry_width(input int id_w, input int aux_w);
    return id_w + aux_w + 1;
  endfunction

endpackage

// File: rtl/axi_resp_fifo2.sv
// rtl/axi_resp_fifo2.sv - two-entry elastic buffer with registered valid/data
module axi_resp_fifo2 #(
  parameter int W = 49
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_tvalid,
  output logic         s_tready,
  input  logic [W-1:0] s_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [W-1:0] m_tdata
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign s_tready = (count != 2'd2);
  assign m_tvalid = (count != 2'd0);
  assign m_tdata  = mem[rd_ptr];
  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage is never reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_tdata;
  end

endmodule

// File: rtl/axi_fanout_resp_primitive.sv
// rtl/axi_fanout_resp_primitive.sv - response fan-out to two initiator ports by one ID bit
// Optional delivered-beat counters enabled by AXI_FANOUT_BEAT_CNT_EN.
module axi_fanout_resp_primitive
  import axi_node_pkg::*;
#(
  parameter int AUX_WIDTH = 32,
  parameter int ID_WIDTH  = 16,
  parameter int ROUTE_BIT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  input  logic [ID_WIDTH-1:0]   data_ID_i,
  input  logic [AUX_WIDTH-1:0]  data_AUX_i,
  input  logic                  data_last_i,
  output logic                  data_valid0_o,
  input  logic                  data_ready0_i,
  output logic [ID_WIDTH-1:0]   data_ID0_o,
  output logic [AUX_WIDTH-1:0]  data_AUX0_o,
  output logic                  data_last0_o,
`ifdef AXI_FANOUT_BEAT_CNT_EN
  output logic [BEAT_CNT_W-1:0] beat_cnt0_o,
  output logic [BEAT_CNT_W-1:0] beat_cnt1_o,
`endif
  output logic                  data_valid1_o,
  input  logic                  data_ready1_i,
  output logic [ID_WIDTH-1:0]   data_ID1_o,
  output logic [AUX_WIDTH-1:0]  data_AUX1_o,
  output logic                  data_last1_o
);

  localparam int EW = entry_width(ID_WIDTH, AUX_WIDTH);

  typedef struct packed {
    logic [ID_WIDTH-1:0]  id;
    logic [AUX_WIDTH-1:0] aux;
    logic                 last;
  } entry_t;

  entry_t in_entry;
  entry_t out0;
  entry_t out1;
  logic   sel;
  logic   rdy0;
  logic   rdy1;

  assign sel          = data_ID_i[ROUTE_BIT];
  assign in_entry     = '{id: data_ID_i, aux: data_AUX_i, last: data_last_i};
  assign data_ready_o = sel ? rdy1 : rdy0;

  axi_resp_fifo2 #(.W(EW)) u_fifo0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tvalid (data_valid_i & ~sel),
    .s_tready (rdy0),
    .s_tdata  (in_entry),
    .m_tvalid (data_valid0_o),
    .m_tready (data_ready0_i),
    .m_tdata  (out0)
  );

  axi_resp_fifo2 #(.W(EW)) u_fifo1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tvalid (data_valid_i & sel),
    .s_tready (rdy1),
    .s_tdata  (in_entry),
    .m_tvalid (data_valid1_o),
    .m_tready (data_ready1_i),
    .m_tdata  (out1)
  );

  assign data_ID0_o   = out0.id;
  assign data_AUX0_o  = out0.aux;
  assign data_last0_o = out0.last;
  assign data_ID1_o   = out1.id;
  assign data_AUX1_o  = out1.aux;
  assign data_last1_o = out1.last;

`ifdef AXI_FANOUT_BEAT_CNT_EN
  logic pop0;
  logic pop1;

  assign pop0 = data_valid0_o & data_ready0_i;
  assign pop1 = data_valid1_o & data_ready1_i;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt0_o <= '0;
      beat_cnt1_o <= '0;
    end else begin
      if (pop0 && beat_cnt0_o != {BEAT_CNT_W{1'b1}}) beat_cnt0_o <= beat_cnt0_o + 1'b1;
      if (pop1 && beat_cnt1_o != {BEAT_CNT_W{1'b1}}) beat_cnt1_o <= beat_cnt1_o + 1'b1;
    end
  end
`endif

endmodule
